// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store execution stage: FSM states,
// opcode field codes and register-select codes.
package load_store_unit_pkg;

  localparam int unsigned REG_WIDTH_DEF  = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [2:0] AAA_ST = 3'b100;
  localparam logic [2:0] AAA_LD = 3'b101;

  localparam logic [1:0] CC_Y = 2'b00;
  localparam logic [1:0] CC_A = 2'b01;
  localparam logic [1:0] CC_X = 2'b10;

  localparam logic [2:0] BBB_IMM_A  = 3'b010;
  localparam logic [2:0] BBB_IMM_XY = 3'b000;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_X = 2'd1;
  localparam logic [1:0] SEL_Y = 2'd2;

endpackage

// File: rtl/load_store_unit_decode.sv
// Combinational classifier for the aaabbbcc opcode: load/store, immediate
// mode, target register and illegal encodings.
module ls_decode
  import load_store_unit_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_imm,
  output logic [1:0] o_reg_sel,
  output logic       o_illegal
);

  logic [2:0] w_aaa;
  logic [2:0] w_bbb;
  logic [1:0] w_cc;

  assign w_aaa = i_opcode[7:5];
  assign w_bbb = i_opcode[4:2];
  assign w_cc  = i_opcode[1:0];

  always_comb begin
    o_is_load  = 1'b0;
    o_is_store = 1'b0;
    o_is_imm   = 1'b0;
    o_reg_sel  = SEL_A;
    o_illegal  = 1'b0;

    unique case (w_cc)
      CC_A:    o_reg_sel = SEL_A;
      CC_X:    o_reg_sel = SEL_X;
      CC_Y:    o_reg_sel = SEL_Y;
      default: o_reg_sel = SEL_A;
    endcase

    if (w_cc == CC_A) begin
      o_is_imm = (w_bbb == BBB_IMM_A);
    end else begin
      o_is_imm = (w_bbb == BBB_IMM_XY);
    end

    o_is_load  = (w_aaa == AAA_LD);
    o_is_store = (w_aaa == AAA_ST);

    // A store cannot target an immediate; cc=11 has no register group.
    if (w_cc == 2'b11 || !(o_is_load || o_is_store) || (o_is_store && o_is_imm)) begin
      o_illegal  = 1'b1;
      o_is_load  = 1'b0;
      o_is_store = 1'b0;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store execution stage: takes a fetched instruction on a ready edge,
// performs the bus transfer or immediate load, writes back and signals done.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned REG_WIDTH   = REG_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  phi1,
  input  logic                  reset,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  imm_in,
  input  logic [REG_WIDTH-1:0]  mem_data_in,
  input  logic [REG_WIDTH-1:0]  a_in,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  y_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_data_out,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic                  reg_wr_en,
  output logic [1:0]            reg_wr_sel,
  output logic [REG_WIDTH-1:0]  reg_wr_data,
  output logic                  flag_upd,
  output logic                  flag_n,
  output logic                  flag_z,
  output logic                  instruction_done,
  output logic                  busy,
  output logic                  illegal,
  output logic                  overrun
);

  localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

  logic [2:0]            r_state;
  logic                  r_ready_prev;
  logic [REG_WIDTH-1:0]  r_opcode;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REG_WIDTH-1:0]  r_imm;
  logic [REG_WIDTH-1:0]  r_data;
  logic [1:0]            r_cnt;
  logic                  r_illegal;
  logic                  r_overrun;
  logic                  r_flag_n;
  logic                  r_flag_z;

  logic                  w_edge;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_is_imm;
  logic [1:0]            w_sel;
  logic                  w_illegal;
  logic [REG_WIDTH-1:0]  w_store_data;

  assign w_edge = instruction_ready && !r_ready_prev;

  ls_decode u_decode (
    .i_opcode   (r_opcode[7:0]),
    .o_is_load  (w_is_load),
    .o_is_store (w_is_store),
    .o_is_imm   (w_is_imm),
    .o_reg_sel  (w_sel),
    .o_illegal  (w_illegal)
  );

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ready_prev <= 1'b1;
      r_opcode     <= '0;
      r_addr       <= '0;
      r_imm        <= '0;
      r_data       <= '0;
      r_cnt        <= '0;
      r_illegal    <= 1'b0;
      r_overrun    <= 1'b0;
      r_flag_n     <= 1'b0;
      r_flag_z     <= 1'b0;
    end else begin
      r_ready_prev <= instruction_ready;
      if (w_edge && r_state != S_IDLE) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_opcode <= instruction_in;
            r_addr   <= addr_in;
            r_imm    <= imm_in;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_is_load && w_is_imm) begin
            r_data  <= r_imm;
            r_state <= S_WB;
          end else if (w_is_load) begin
            r_cnt   <= '0;
            r_state <= S_READ;
          end else if (w_is_store) begin
            r_state <= S_WRITE;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_READ: begin
          if (r_cnt == LAST_CNT) begin
            r_data  <= mem_data_in;
            r_state <= S_WB;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_WRITE: r_state <= S_DONE;
        S_WB: begin
          r_flag_n <= r_data[REG_WIDTH-1];
          r_flag_z <= (r_data == '0);
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_illegal <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    unique case (w_sel)
      SEL_X:   w_store_data = x_in;
      SEL_Y:   w_store_data = y_in;
      default: w_store_data = a_in;
    endcase
  end

  assign busy             = (r_state != S_IDLE);
  assign mem_re           = (r_state == S_READ);
  assign mem_we           = (r_state == S_WRITE);
  assign mem_addr         = (mem_re || mem_we) ? r_addr : '0;
  assign mem_data_out     = mem_we ? w_store_data : '0;
  assign reg_wr_en        = (r_state == S_WB);
  assign reg_wr_sel       = reg_wr_en ? w_sel : '0;
  assign reg_wr_data      = reg_wr_en ? r_data : '0;
  assign flag_upd         = reg_wr_en;
  // Flags show the new result during WB, then the held copy afterwards.
  assign flag_n           = reg_wr_en ? r_data[REG_WIDTH-1] : r_flag_n;
  assign flag_z           = reg_wr_en ? (r_data == '0) : r_flag_z;
  assign instruction_done = (r_state == S_DONE);
  assign illegal          = instruction_done && r_illegal;
  assign overrun          = r_overrun;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with MEM_LATENCY=2 and a small memory map.
module tb_load_store_unit;

  logic        phi1 = 1'b0;
  logic        reset = 1'b1;
  logic        instruction_ready = 1'b0;
  logic [7:0]  instruction_in = '0;
  logic [15:0] addr_in = '0;
  logic [7:0]  imm_in = '0;
  logic [7:0]  mem_data_in;
  logic [7:0]  a_in = '0;
  logic [7:0]  x_in = '0;
  logic [7:0]  y_in = '0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_re, mem_we, reg_wr_en;
  logic [1:0]  reg_wr_sel;
  logic [7:0]  reg_wr_data;
  logic        flag_upd, flag_n, flag_z;
  logic        instruction_done, busy, illegal, overrun;

  int total = 0;
  int bad = 0;

  int          done_cyc, re_n, we_n, wr_n, fu_n, prot_err, busy_n;
  logic [15:0] re_addr, we_addr;
  logic [7:0]  we_data, wr_data;
  logic [1:0]  wr_sel;
  logic        fn, fz, ill;

  always #5 phi1 = ~phi1;

  load_store_unit #(
    .REG_WIDTH   (8),
    .ADDR_WIDTH  (16),
    .MEM_LATENCY (2)
  ) dut (
    .phi1              (phi1),
    .reset             (reset),
    .instruction_ready (instruction_ready),
    .instruction_in    (instruction_in),
    .addr_in           (addr_in),
    .imm_in            (imm_in),
    .mem_data_in       (mem_data_in),
    .a_in              (a_in),
    .x_in              (x_in),
    .y_in              (y_in),
    .mem_addr          (mem_addr),
    .mem_data_out      (mem_data_out),
    .mem_re            (mem_re),
    .mem_we            (mem_we),
    .reg_wr_en         (reg_wr_en),
    .reg_wr_sel        (reg_wr_sel),
    .reg_wr_data       (reg_wr_data),
    .flag_upd          (flag_upd),
    .flag_n            (flag_n),
    .flag_z            (flag_z),
    .instruction_done  (instruction_done),
    .busy              (busy),
    .illegal           (illegal),
    .overrun           (overrun)
  );

  always_comb begin
    mem_data_in = 8'h00;
    if (mem_re) begin
      case (mem_addr)
        16'h1234: mem_data_in = 8'h00;
        16'h2000: mem_data_in = 8'hC3;
        default:  mem_data_in = 8'h77;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge phi1);
    #1;
  endtask

  task automatic sample_cycle;
    if (mem_re) begin re_n++; re_addr = mem_addr; end
    if (mem_we) begin we_n++; we_addr = mem_addr; we_data = mem_data_out; end
    if (reg_wr_en) begin wr_n++; wr_sel = reg_wr_sel; wr_data = reg_wr_data; end
    if (flag_upd) begin fu_n++; fn = flag_n; fz = flag_z; end
    if (mem_re && mem_we) prot_err++;
    if (!mem_re && !mem_we && mem_addr != 16'h0000) prot_err++;
  endtask

  // Raises ready and steps until done (bounded); glitch drops and re-raises
  // ready mid-op to provoke an overrun.
  task automatic run_op(input logic [7:0] op, input logic [15:0] ad,
                        input logic [7:0] im, input bit glitch);
    instruction_in = op;
    addr_in = ad;
    imm_in = im;
    instruction_ready = 1'b1;
    done_cyc = 0; re_n = 0; we_n = 0; wr_n = 0; fu_n = 0;
    re_addr = '0; we_addr = '0; we_data = '0; wr_data = '0; wr_sel = '0;
    fn = 1'b0; fz = 1'b0; ill = 1'b0;
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      step();
      sample_cycle();
      if (instruction_done) begin
        done_cyc = c;
        ill = illegal;
      end
      if (glitch && c == 1) instruction_ready = 1'b0;
      if (glitch && c == 2) instruction_ready = 1'b1;
    end
    instruction_ready = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    prot_err = 0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_done", instruction_done, 0);
    chk("rst_flags", {flag_n, flag_z, overrun, illegal}, 4'b0000);
    reset = 1'b0;
    step();

    run_op(8'hA9, 16'h0000, 8'h80, 1'b0);
    chk("lda_imm_done", done_cyc, 3);
    chk("lda_imm_re", re_n, 0);
    chk("lda_imm_wr", wr_n, 1);
    chk("lda_imm_sel", wr_sel, 0);
    chk("lda_imm_data", wr_data, 8'h80);
    chk("lda_imm_nz", {fn, fz}, 2'b10);
    chk("lda_imm_ill", ill, 0);
    chk("lda_imm_idle", busy, 0);
    chk("lda_imm_nhold", flag_n, 1);

    run_op(8'hAE, 16'h1234, 8'h00, 1'b0);
    chk("ldx_mem_done", done_cyc, 5);
    chk("ldx_mem_re", re_n, 2);
    chk("ldx_mem_addr", re_addr, 16'h1234);
    chk("ldx_mem_sel", wr_sel, 1);
    chk("ldx_mem_data", wr_data, 8'h00);
    chk("ldx_mem_nz", {fn, fz}, 2'b01);

    y_in = 8'h5A;
    run_op(8'h84, 16'h0042, 8'h00, 1'b0);
    chk("sty_done", done_cyc, 3);
    chk("sty_we", we_n, 1);
    chk("sty_addr", we_addr, 16'h0042);
    chk("sty_data", we_data, 8'h5A);
    chk("sty_wr", wr_n, 0);
    chk("sty_fu", fu_n, 0);
    chk("sty_zhold", flag_z, 1);

    run_op(8'hEA, 16'h3000, 8'h11, 1'b0);
    chk("ill_ea_done", done_cyc, 2);
    chk("ill_ea_flag", ill, 1);
    chk("ill_ea_bus", re_n + we_n + wr_n + fu_n, 0);
    chk("ill_ea_after", illegal, 0);

    run_op(8'h89, 16'h3000, 8'h11, 1'b0);
    chk("ill_89_done", done_cyc, 2);
    chk("ill_89_flag", ill, 1);
    chk("ill_89_bus", re_n + we_n + wr_n + fu_n, 0);

    a_in = 8'h3C;
    run_op(8'h8D, 16'hFFFF, 8'h00, 1'b0);
    chk("sta_ffff_done", done_cyc, 3);
    chk("sta_ffff_addr", we_addr, 16'hFFFF);
    chk("sta_ffff_data", we_data, 8'h3C);

    chk("ovr_before", overrun, 0);
    run_op(8'hAD, 16'h2000, 8'h00, 1'b1);
    chk("ovr_done", done_cyc, 5);
    chk("ovr_data", wr_data, 8'hC3);
    chk("ovr_sel", wr_sel, 0);
    chk("ovr_nz", {fn, fz}, 2'b10);
    chk("ovr_set", overrun, 1);
    chk("ovr_idle", busy, 0);

    run_op(8'hA0, 16'h0000, 8'h00, 1'b0);
    chk("ldy_imm_done", done_cyc, 3);
    chk("ldy_imm_sel", wr_sel, 2);
    chk("ldy_imm_z", fz, 1);
    chk("ovr_sticky", overrun, 1);

    instruction_in = 8'hAE;
    addr_in = 16'h1234;
    instruction_ready = 1'b1;
    step();
    step();
    chk("mid_in_read", mem_re, 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_re", mem_re, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", mem_addr, 16'h0000);
    chk("mid_rst_sticky", {overrun, flag_z}, 2'b00);
    step();
    reset = 1'b0;
    busy_n = 0; wr_n = 0; we_n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy) busy_n++;
      if (reg_wr_en) wr_n++;
      if (mem_we) we_n++;
    end
    chk("post_rst_nostart", busy_n + wr_n + we_n, 0);
    instruction_ready = 1'b0;
    step();

    run_op(8'hA2, 16'h0000, 8'h05, 1'b0);
    chk("ldx_imm_done", done_cyc, 3);
    chk("ldx_imm_sel", wr_sel, 1);
    chk("ldx_imm_data", wr_data, 8'h05);

    chk("bus_protocol", prot_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
